mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Parametrised MEM stage of the Minisys pipeline. It sits between EXE/MEM and MEM/WB and holds the word-organised byte-lane data RAM. Stores are lane-enabled from size and address; loads are aligned and sign/zero-extended in one place. An address window is routed to a memory-mapped I/O port with a req/ack handshake, a pipeline stall and a timeout. The block also owns the MEM/WB pipeline register.

## Interface
Parameters:
- ADDR_W, 14: word-index width of the internal RAM; depth is 2**ADDR_W words.
- IO_PREFIX, 8'hFF: value of alu_outM[31:24] that selects the I/O window.
- IO_TIMEOUT, 255: maximum number of WAIT cycles before a bus error; 8-bit counter.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- validM  in  1  M-stage slot holds a real instruction.
- memreadM, memwriteM  in  1 each  load / store.
- sizeM  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- signedM  in  1  sign-extend loads.
- alu_outM  in  32  effective address, or ALU result.
- write_dataM  in  32  store data.
- regwriteM, mem2regM, write_31M, mfhiM, mfloM  in  1 each  WB controls.
- write_regM  in  5  destination register.
- pcplus4M, hi2rdataM, lo2rdataM  in  32 each  pass-through.
- stallM  out  1  hold IF..M; insert a bubble into W.
- misalignM  out  1  combinational misaligned-access flag.
- io_req, io_we  out  1 each  I/O request and direction.
- io_addr, io_wdata  out  32 each  I/O address and write data.
- io_be  out  4  I/O byte enables.
- io_ack  in  1  I/O completion.
- io_rdata  in  32  I/O read data.
- regwriteW, mem2regW, write_31W, mfhiW, mfloW, misalignW, bus_errW  out  1 each  registered WB controls and flags.
- write_regW  out  5  registered destination register.
- alu_outW, read_dataW, pcplus4W, hi2rdataW, lo2rdataW  out  32 each  registered data.

## Operation
- Access decode:
  - access = validM & (memreadM | memwriteM).
  - io_sel = access & (alu_outM[31:24] == IO_PREFIX).
- Misalignment:
  - misalignM = access & ((half & a[0]) | (word & a[1:0] != 0)).
  - A misaligned access writes no RAM, starts no I/O and reaches W with regwriteW = 0 and misalignW = 1.
- Byte enables (little endian):
  - byte: be = 1 << a[1:0].
  - half: be = a[1] ? 1100 : 0011.
  - word: be = 1111.
  - Store data is replicated across the lanes: byte as {4{d[7:0]}}, half as {2{d[15:0]}}.
- RAM write: on clk when memwriteM, access, !io_sel and !misalignM, each enabled lane is written at word index alu_outM[ADDR_W+1:2].
- Load alignment, done in W from the registered addr[1:0], size and signed:
  - Select the lane(s), then extend to 32 bits.
  - Source is RAM douta, or the captured I/O data when the access was I/O.
- I/O FSM, states IDLE, WAIT, DONE:
  - IDLE: io_sel & !misalignM → WAIT; stallM = 1 in this cycle (combinational).
  - WAIT:
    - io_req = 1; io_addr, io_we, io_be and io_wdata are driven from the held M inputs; stallM = 1; the counter increments.
    - io_ack → capture io_rdata, go to DONE.
    - Otherwise, count == IO_TIMEOUT → latch bus error, capture 0, go to DONE.
  - DONE: stallM = 0; the held instruction commits into W with the I/O data and bus_errW; next state IDLE.
- Stall handling:
  - While stallM = 1, W loads a bubble: all control bits 0, data registers hold.
  - The M inputs are held stable by upstream.
- Pass-through: on every non-stalled cycle, alu_outW, pcplus4W, hi/lo, write_regW and the control bits register their M values.

## Timing
- Reset (clrn = 0, asynchronous):
  - All W outputs 0.
  - FSM IDLE, counter 0.
  - io_req = 0, stallM = 0.
- Reset takes effect mid-WAIT: io_req drops immediately, and there is no commit.
- RAM loads: one clock latency, no stall; read_dataW is valid in the W cycle.
- A store in cycle t followed by a load to the same word in cycle t+1 returns the new data.
- I/O access: the instruction reaches W after 2 + k cycles, where k is the cycle count from WAIT entry to io_ack.
  - io_ack in the first WAIT cycle gives k = 1.
  - Timeout gives IO_TIMEOUT + 1 WAIT cycles.
- io_ack outside WAIT is ignored.
- bus_errW and misalignW are high for exactly one W cycle.

## Structure
- Shared package mem_pkg holds:
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state enum;
  - the default IO_PREFIX;
  - the lane-enable function.
- One sub-module, byte_lane_ram: four synchronous byte-wide banks of 2**ADDR_W entries, one write enable per lane, 1-cycle registered read.

## Test plan
- sb 0x80 to 0x00000003, then lb from the same address → read_dataW = 0xFFFFFF80; lbu from the same address → 0x00000080.
- sh 0xBEEF to 0x00000006, then lh → 0xFFFFBEEF; lw 0x00000004 → 0xBEEFxxxx with lanes 0–1 unchanged.
- lw from 0x00000102 → misalignM = 1, no RAM write, misalignW = 1 and regwriteW = 0 one cycle later.
- lw from 0xFF000010 with io_ack and io_rdata = 0x12345678 three cycles after io_req rises → stallM high for 4 cycles, read_dataW = 0x12345678, bus_errW = 0.
- I/O store with io_ack never asserted, IO_TIMEOUT = 4 → io_req high for 5 cycles, then bus_errW = 1 for one cycle, read data 0.
- Drive clrn low during WAIT → io_req and stallM drop asynchronously and W outputs become 0; after release, a RAM load completes normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_pkg: shared encodings, FSM states and lane helpers for the MEM stage.
// Holds the size codes, the I/O state enum, the default I/O prefix and the lane/extend functions.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [7:0] IO_PREFIX_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } io_state_e;

    // Size 11 falls through to the word case.
    function automatic logic [3:0] lane_be(
        input logic [1:0] size,
        input logic [1:0] a
    );
        if (size == SZ_BYTE) return 4'b0001 << a;
        if (size == SZ_HALF) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] load_align(
        input logic [31:0] w,
        input logic [1:0]  size,
        input logic [1:0]  a,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (size == SZ_BYTE) return {{24{sgn & b[7]}}, b};
        if (size == SZ_HALF) return {{16{sgn & h[15]}}, h};
        return w;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: memory-mapped I/O bus between the MEM stage and a device.
// master drives req/we/addr/wdata/be; slave returns ack and rdata.
interface mem_access_stage_if;

    logic        io_req;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_be;
    logic        io_ack;
    logic [31:0] io_rdata;

    modport master (
        output io_req, io_we, io_addr, io_wdata, io_be,
        input  io_ack, io_rdata
    );

    modport slave (
        input  io_req, io_we, io_addr, io_wdata, io_be,
        output io_ack, io_rdata
    );

endinterface

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: four byte-wide synchronous banks with per-lane write enables.
// Ports: clk, we_i[3:0], addr_i (word index), wdata_i, rdata_o (registered, 1-cycle).
module byte_lane_ram #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] dout_q;

        // Read returns the pre-write contents on a same-edge write.
        always_ff @(posedge clk) begin
            if (we_i[l]) mem_q[addr_i] <= wdata_i[8*l +: 8];
            dout_q <= mem_q[addr_i];
        end

        assign rdata_o[8*l +: 8] = dout_q;
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with byte-lane data RAM, MMIO port and the MEM/WB register.
// Ports: clk/clrn, M-stage controls and data in, stallM/misalignM out, io (master), W outputs.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 14,
    parameter logic [7:0]  IO_PREFIX  = IO_PREFIX_DEF,
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        validM,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic        signedM,
    input  logic [31:0] alu_outM,
    input  logic [31:0] write_dataM,
    input  logic        regwriteM,
    input  logic        mem2regM,
    input  logic        write_31M,
    input  logic        mfhiM,
    input  logic        mfloM,
    input  logic [4:0]  write_regM,
    input  logic [31:0] pcplus4M,
    input  logic [31:0] hi2rdataM,
    input  logic [31:0] lo2rdataM,
    output logic        stallM,
    output logic        misalignM,
    mem_access_stage_if.master io,
    output logic        regwriteW,
    output logic        mem2regW,
    output logic        write_31W,
    output logic        mfhiW,
    output logic        mfloW,
    output logic        misalignW,
    output logic        bus_errW,
    output logic [4:0]  write_regW,
    output logic [31:0] alu_outW,
    output logic [31:0] read_dataW,
    output logic [31:0] pcplus4W,
    output logic [31:0] hi2rdataW,
    output logic [31:0] lo2rdataW
);

    localparam logic [7:0] TMO = 8'(IO_TIMEOUT);

    logic        access;
    logic        io_sel;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misal;
    logic        io_start;
    logic [3:0]  be;
    logic [31:0] st_data;
    logic [3:0]  ram_we;
    logic [31:0] douta;

    io_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] iodata_q, iodata_d;
    logic        berr_q, berr_d;
    logic        stall;
    logic        req;

    logic        ld_q;
    logic        io_src_q;
    logic [1:0]  size_q;
    logic        sgn_q;

    assign access   = validM & (memreadM | memwriteM);
    assign io_sel   = access & (alu_outM[31:24] == IO_PREFIX);
    assign is_byte  = sizeM == SZ_BYTE;
    assign is_half  = sizeM == SZ_HALF;
    assign is_word  = sizeM[1];
    assign misal    = access & ((is_half & alu_outM[0]) |
                                (is_word & (alu_outM[1:0] != 2'b00)));
    assign io_start = io_sel & ~misal;
    assign be       = lane_be(sizeM, alu_outM[1:0]);

    assign misalignM = misal;

    always_comb begin
        st_data = write_dataM;
        unique case (1'b1)
            is_byte: st_data = {4{write_dataM[7:0]}};
            is_half: st_data = {2{write_dataM[15:0]}};
            default: ;
        endcase
    end

    assign ram_we = be & {4{memwriteM & access & ~io_sel & ~misal}};

    byte_lane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (alu_outM[ADDR_W+1:2]),
        .wdata_i (st_data),
        .rdata_o (douta)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        iodata_d = iodata_q;
        berr_d   = berr_q;
        stall    = 1'b0;
        req      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (io_start) begin
                    stall   = 1'b1;
                    berr_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                req   = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (io.io_ack) begin
                    iodata_d = io.io_rdata;
                    state_d  = ST_DONE;
                end else if (cnt_q == TMO) begin
                    iodata_d = '0;
                    berr_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            iodata_q <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            iodata_q <= iodata_d;
            berr_q   <= berr_d;
        end
    end

    // Gating with clrn keeps the IDLE-cycle stall from showing while held in reset.
    assign stallM = stall & clrn;

    assign io.io_req   = req;
    assign io.io_we    = req & memwriteM;
    assign io.io_addr  = req ? alu_outM : '0;
    assign io.io_be    = req ? be : '0;
    assign io.io_wdata = req ? st_data : '0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            regwriteW  <= 1'b0;
            mem2regW   <= 1'b0;
            write_31W  <= 1'b0;
            mfhiW      <= 1'b0;
            mfloW      <= 1'b0;
            misalignW  <= 1'b0;
            bus_errW   <= 1'b0;
            ld_q       <= 1'b0;
            io_src_q   <= 1'b0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            write_regW <= '0;
            alu_outW   <= '0;
            pcplus4W   <= '0;
            hi2rdataW  <= '0;
            lo2rdataW  <= '0;
        end else if (stall) begin
            regwriteW  <= 1'b0;
            mem2regW   <= 1'b0;
            write_31W  <= 1'b0;
            mfhiW      <= 1'b0;
            mfloW      <= 1'b0;
            misalignW  <= 1'b0;
            bus_errW   <= 1'b0;
            ld_q       <= 1'b0;
            io_src_q   <= 1'b0;
        end else begin
            regwriteW  <= regwriteM & ~misal;
            mem2regW   <= mem2regM;
            write_31W  <= write_31M;
            mfhiW      <= mfhiM;
            mfloW      <= mfloM;
            misalignW  <= misal;
            bus_errW   <= berr_q & (state_q == ST_DONE);
            ld_q       <= memreadM & access & ~misal;
            io_src_q   <= state_q == ST_DONE;
            size_q     <= sizeM;
            sgn_q      <= signedM;
            write_regW <= write_regM;
            alu_outW   <= alu_outM;
            pcplus4W   <= pcplus4M;
            hi2rdataW  <= hi2rdataM;
            lo2rdataW  <= lo2rdataM;
        end
    end

    // RAM data arrives one cycle after the address, so alignment happens here in W.
    assign read_dataW = ld_q ?
        load_align(io_src_q ? iodata_q : douta, size_q, alu_outW[1:0], sgn_q) : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage.
// Drives M-stage ops, models RAM and an I/O device, checks W outputs and timing.
module tb_mem_access_stage;
    import mem_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        validM = 1'b0;
    logic        memreadM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [1:0]  sizeM = 2'b00;
    logic        signedM = 1'b0;
    logic [31:0] alu_outM = '0;
    logic [31:0] write_dataM = '0;
    logic        regwriteM = 1'b0;
    logic        mem2regM = 1'b0;
    logic        write_31M = 1'b0;
    logic        mfhiM = 1'b0;
    logic        mfloM = 1'b0;
    logic [4:0]  write_regM = '0;
    logic [31:0] pcplus4M = '0;
    logic [31:0] hi2rdataM = '0;
    logic [31:0] lo2rdataM = '0;
    logic        stallM, misalignM;
    logic        regwriteW, mem2regW, write_31W, mfhiW, mfloW;
    logic        misalignW, bus_errW;
    logic [4:0]  write_regW;
    logic [31:0] alu_outW, read_dataW, pcplus4W, hi2rdataW, lo2rdataW;

    always #5 clk = ~clk;

    mem_access_stage_if io_bus ();

    mem_access_stage #(
        .IO_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .validM      (validM),
        .memreadM    (memreadM),
        .memwriteM   (memwriteM),
        .sizeM       (sizeM),
        .signedM     (signedM),
        .alu_outM    (alu_outM),
        .write_dataM (write_dataM),
        .regwriteM   (regwriteM),
        .mem2regM    (mem2regM),
        .write_31M   (write_31M),
        .mfhiM       (mfhiM),
        .mfloM       (mfloM),
        .write_regM  (write_regM),
        .pcplus4M    (pcplus4M),
        .hi2rdataM   (hi2rdataM),
        .lo2rdataM   (lo2rdataM),
        .stallM      (stallM),
        .misalignM   (misalignM),
        .io          (io_bus),
        .regwriteW   (regwriteW),
        .mem2regW    (mem2regW),
        .write_31W   (write_31W),
        .mfhiW       (mfhiW),
        .mfloW       (mfloW),
        .misalignW   (misalignW),
        .bus_errW    (bus_errW),
        .write_regW  (write_regW),
        .alu_outW    (alu_outW),
        .read_dataW  (read_dataW),
        .pcplus4W    (pcplus4W),
        .hi2rdataW   (hi2rdataW),
        .lo2rdataW   (lo2rdataW)
    );

    typedef struct {
        int          t;
        int          lat;
        logic        rw;
        logic        mis;
        logic        berr;
        logic        chk_rd;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          req_cnt = 0;
    int          req_n = 0;
    int          dev_ack_at = 0;
    logic        stray = 1'b0;
    logic [31:0] dev_data = '0;
    logic [31:0] x_addr = '0;
    logic [31:0] x_wdata = '0;
    logic        x_we = 1'b0;
    logic [3:0]  x_be = '0;
    logic        pend = 1'b0;
    logic [7:0]  mdl [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mb(input logic [31:0] x);
        return mdl.exists(x) ? mdl[x] : 8'h00;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [31:0] a,
                                        input logic [1:0] sz, input logic sg);
        logic [31:0] sh;
        sh = w >> (8 * int'(a[1:0]));
        if (sz == 2'b00) return sg ? 32'($signed(sh[7:0])) : {24'h0, sh[7:0]};
        if (sz == 2'b01) return sg ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a,
                                             input logic [1:0] sz, input logic sg);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return ext({mb(b + 3), mb(b + 2), mb(b + 1), mb(b)}, a, sz, sg);
    endfunction

    task automatic mdl_store(input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd);
        for (int i = 0; i < 4; i++)
            if (be[i]) mdl[{a[31:2], 2'b00} + 32'(i)] = wd[8*i +: 8];
    endtask

    always @(posedge clk) cyc++;

    // I/O device: acks in the dev_ack_at-th request cycle (0 = never).
    always @(posedge clk) begin
        #1;
        io_bus.io_rdata = dev_data;
        if (io_bus.io_req) begin
            req_n++;
            io_bus.io_ack = stray || (dev_ack_at != 0 && req_n == dev_ack_at);
        end else begin
            req_n = 0;
            io_bus.io_ack = stray;
        end
    end

    always @(negedge clk) begin
        if (io_bus.io_req) begin
            req_cnt++;
            check("io_addr", io_bus.io_addr, x_addr);
            check("io_we", 32'(io_bus.io_we), 32'(x_we));
            check("io_be", 32'(io_bus.io_be), 32'(x_be));
            if (x_we) check("io_wdata", io_bus.io_wdata, x_wdata);
        end
        if (pend) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                me = sb.pop_front();
                check("latency", 32'(cyc - me.t), 32'(me.lat));
                check("regwriteW", 32'(regwriteW), 32'(me.rw));
                check("misalignW", 32'(misalignW), 32'(me.mis));
                check("bus_errW", 32'(bus_errW), 32'(me.berr));
                check("alu_outW", alu_outW, me.alu);
                check("pcplus4W", pcplus4W, me.alu + 32'd4);
                check("write_regW", 32'(write_regW), 32'(me.wreg));
                if (me.chk_rd) check("read_dataW", read_dataW, me.rd);
            end
        end
        pend = clrn && validM && !stallM;
    end

    task automatic idle_m();
        validM = 1'b0;
        memreadM = 1'b0;
        memwriteM = 1'b0;
        regwriteM = 1'b0;
        mem2regM = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d,
                         input logic rw, input int ack_at, input logic [31:0] io_d);
        exp_t       e;
        logic       mis, io, go, done;
        logic [3:0] be;
        int         k, stalls;
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        io = a[31:24] == 8'hFF;
        go = io && !mis;
        be = (sz == 2'b00) ? (4'b0001 << a[1:0]) :
             (sz == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        x_addr = a;
        x_we = wr;
        x_be = be;
        x_wdata = (sz == 2'b00) ? {4{d[7:0]}} : (sz == 2'b01) ? {2{d[15:0]}} : d;
        dev_ack_at = ack_at;
        dev_data = io_d;
        req_cnt = 0;
        k = (ack_at != 0) ? ack_at : TMO + 1;
        e.t = cyc;
        e.lat = go ? 2 + k : 1;
        e.rw = rw && !mis;
        e.mis = mis;
        e.berr = go && ack_at == 0;
        e.alu = a;
        e.wreg = 5'(cyc);
        e.chk_rd = 1'b0;
        e.rd = '0;
        if (e.berr) begin
            e.chk_rd = 1'b1;
        end else if (rd && !mis) begin
            e.chk_rd = 1'b1;
            e.rd = go ? ext(io_d, a, sz, sg) : mdl_load(a, sz, sg);
        end
        if (wr && !mis && !io) mdl_store(a, be, x_wdata);
        validM = 1'b1;
        memreadM = rd;
        memwriteM = wr;
        sizeM = sz;
        signedM = sg;
        alu_outM = a;
        write_dataM = d;
        regwriteM = rw;
        mem2regM = rd;
        write_regM = e.wreg;
        pcplus4M = a + 32'd4;
        hi2rdataM = ~a;
        lo2rdataM = a ^ 32'h55;
        sb.push_back(e);
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) check("misalignM", 32'(misalignM), 32'(mis));
            if (!stallM) done = 1'b1;
            else stalls++;
        end
        check("accept_in_budget", 32'(done), 32'd1);
        check("stall_cycles", 32'(stalls), go ? 32'(1 + k) : 32'd0);
        if (go) check("io_req_cycles", 32'(req_cnt), 32'(k));
        @(posedge clk);
        #1;
        idle_m();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io_bus.io_ack = 1'b0;
        io_bus.io_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_stallM", 32'(stallM), 32'd0);
        check("rst_io_req", 32'(io_bus.io_req), 32'd0);
        check("rst_regwriteW", 32'(regwriteW), 32'd0);
        check("rst_alu_outW", alu_outW, 32'd0);
        check("rst_read_dataW", read_dataW, 32'd0);
        check("rst_bus_errW", 32'(bus_errW), 32'd0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 1, SZ_WORD, 0, 32'h0, 32'h11223344, 0, 0, 0);
        issue(0, 1, SZ_WORD, 0, 32'h4, 32'hA5A5C3C3, 0, 0, 0);
        issue(0, 1, SZ_WORD, 0, 32'h8, 32'hCAFEF00D, 0, 0, 0);
        issue(0, 1, SZ_BYTE, 0, 32'h3, 32'h00000080, 0, 0, 0);
        issue(1, 0, SZ_BYTE, 1, 32'h3, 32'h0, 1, 0, 0);
        issue(1, 0, SZ_BYTE, 0, 32'h3, 32'h0, 1, 0, 0);
        issue(0, 1, SZ_HALF, 0, 32'h6, 32'h0000BEEF, 0, 0, 0);
        issue(1, 0, SZ_HALF, 1, 32'h6, 32'h0, 1, 0, 0);
        issue(1, 0, SZ_WORD, 0, 32'h4, 32'h0, 1, 0, 0);
        issue(1, 0, SZ_HALF, 0, 32'h4, 32'h0, 1, 0, 0);
        issue(1, 0, SZ_BYTE, 1, 32'h1, 32'h0, 1, 0, 0);
        issue(1, 0, 2'b11, 0, 32'h0, 32'h0, 1, 0, 0);

        issue(1, 0, SZ_WORD, 0, 32'h102, 32'h0, 1, 0, 0);
        issue(0, 1, SZ_WORD, 0, 32'hA, 32'h01020304, 0, 0, 0);
        issue(1, 0, SZ_HALF, 1, 32'h9, 32'h0, 1, 0, 0);
        issue(1, 0, SZ_WORD, 0, 32'h8, 32'h0, 1, 0, 0);

        stray = 1'b1;
        issue(1, 0, SZ_WORD, 0, 32'h0, 32'h0, 1, 0, 0);
        stray = 1'b0;

        issue(1, 0, SZ_WORD, 0, 32'hFF000010, 32'h0, 1, 3, 32'h12345678);
        issue(1, 0, SZ_BYTE, 1, 32'hFF000013, 32'h0, 1, 1, 32'h9A000000);
        issue(0, 1, SZ_WORD, 0, 32'hFF000020, 32'hDEADBEEF, 0, 0, 0);
        issue(0, 1, SZ_BYTE, 0, 32'hFF000021, 32'h000000AB, 0, 2, 0);
        issue(1, 0, SZ_WORD, 0, 32'h4, 32'h0, 1, 0, 0);

        // Reset in the middle of an I/O wait.
        x_addr = 32'hFF000030;
        x_we = 1'b0;
        x_be = 4'hF;
        dev_ack_at = 0;
        validM = 1'b1;
        memreadM = 1'b1;
        sizeM = SZ_WORD;
        alu_outM = 32'hFF000030;
        regwriteM = 1'b1;
        pcplus4M = 32'hFF000034;
        @(negedge clk);
        @(negedge clk);
        check("wait_io_req", 32'(io_bus.io_req), 32'd1);
        #2;
        clrn = 1'b0;
        #1;
        check("arst_io_req", 32'(io_bus.io_req), 32'd0);
        check("arst_stallM", 32'(stallM), 32'd0);
        check("arst_regwriteW", 32'(regwriteW), 32'd0);
        check("arst_alu_outW", alu_outW, 32'd0);
        check("arst_pcplus4W", pcplus4W, 32'd0);
        check("arst_read_dataW", read_dataW, 32'd0);
        @(posedge clk);
        #1;
        idle_m();
        @(posedge clk);
        #1;
        clrn = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 0, SZ_WORD, 0, 32'h8, 32'h0, 1, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
